// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt scheduler: FSM encodings, RET opcode,
// config register addresses and CTRL bit layout.
package irq_pkg;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t S_IDLE    = 2'd0;
  localparam irq_state_t S_ISSUE   = 2'd1;
  localparam irq_state_t S_SERVICE = 2'd2;
  localparam irq_state_t S_RETIRE  = 2'd3;

  localparam logic [5:0] OP_RET = 6'b010000;

  localparam logic CFG_MASK = 1'b0;
  localparam logic CFG_CTRL = 1'b1;

  localparam int CTRL_GEN_BIT  = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int CTRL_PEND_LSB = 2;

  // Per-source entry address; 16-bit truncating arithmetic, wrap-around allowed.
  function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [2:0]  id);
    logic [15:0] offset;
    offset = {13'd0, id} * stride;
    return base + offset;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = req[i] ? 3'(i) : idx;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/irq_scheduler.sv
// Multi-source interrupt scheduler: edge capture, mask, fixed priority, one-at-a-time
// delivery held off until RET. Define IRQ_VECTORED_EN for per-source entry vectors.
module irq_scheduler #(
  parameter int          NUM_SRC    = 4,
  parameter logic [15:0] VEC_BASE   = 16'hF000,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [5:0]         op,
  input  logic               cfg_we,
  input  logic               cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               interrupt,
  output logic [15:0]        vector,
  output logic [2:0]         active_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);
  import irq_pkg::*;

  logic [NUM_SRC-1:0] src_q_r;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] pending_r;
  logic               gen_r;
  irq_state_t         state_r;
  logic               interrupt_r;
  logic               in_service_r;
  logic [2:0]         active_id_r;
  logic [15:0]        vector_r;

  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] elig_s;
  logic [NUM_SRC-1:0] grant_clr_s;
  logic [NUM_SRC-1:0] pend_nxt_s;
  irq_state_t         state_nxt_s;
  logic               grant_s;
  logic               win_vld_s;
  logic [2:0]         win_s;
  logic [15:0]        vec_nxt_s;
  logic [15:0]        rdata_s;
  logic               mask_we_s;
  logic               ctrl_we_s;
  logic               sw_clr_s;
  logic               ret_s;
  logic               unused_cfg_s;

  assign edge_s    = irq_src & ~src_q_r;
  assign elig_s    = gen_r ? (pending_r & ~mask_r) : {NUM_SRC{1'b0}};
  assign mask_we_s = cfg_we && (cfg_addr == CFG_MASK);
  assign ctrl_we_s = cfg_we && (cfg_addr == CFG_CTRL);
  assign sw_clr_s  = ctrl_we_s && cfg_wdata[CTRL_CLR_BIT];
  assign ret_s     = (op == OP_RET);
  assign unused_cfg_s = ^cfg_wdata;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (elig_s),
    .valid (win_vld_s),
    .idx   (win_s)
  );

  // Next-state logic; a grant can only happen from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (win_vld_s) begin
          state_nxt_s = S_ISSUE;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE:   state_nxt_s = S_SERVICE;
      S_SERVICE: begin
        if (ret_s) begin
          state_nxt_s = S_RETIRE;
        end else begin
          state_nxt_s = S_SERVICE;
        end
      end
      S_RETIRE:  state_nxt_s = S_IDLE;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // Pending update: a new edge always wins over grant clear and software clear.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_clr_s[i] = grant_s && (win_s == 3'(i));
    end
    if (sw_clr_s) begin
      pend_nxt_s = edge_s;
    end else begin
      pend_nxt_s = (pending_r & ~grant_clr_s) | edge_s;
    end
  end

  // Entry vector for the winning source.
  always_comb begin
`ifdef IRQ_VECTORED_EN
    vec_nxt_s = irq_vector(VEC_BASE, VEC_STRIDE, win_s);
`else
    vec_nxt_s = VEC_BASE;
`endif
  end

  // Combinational config readback.
  always_comb begin
    rdata_s = 16'h0000;
    case (cfg_addr)
      CFG_MASK: rdata_s[NUM_SRC-1:0] = mask_r;
      CFG_CTRL: begin
        rdata_s[NUM_SRC+1:CTRL_PEND_LSB] = pending_r;
        rdata_s[CTRL_GEN_BIT]            = gen_r;
      end
      default:  rdata_s = 16'h0000;
    endcase
  end

  // Edge sampling, pending latch and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q_r   <= {NUM_SRC{1'b0}};
      pending_r <= {NUM_SRC{1'b0}};
      state_r   <= S_IDLE;
    end else begin
      src_q_r   <= irq_src;
      pending_r <= pend_nxt_s;
      state_r   <= state_nxt_s;
    end
  end

  // Config registers; the grant above already used the pre-write mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r <= {NUM_SRC{1'b0}};
      gen_r  <= 1'b0;
    end else begin
      if (mask_we_s) begin
        mask_r <= cfg_wdata[NUM_SRC-1:0];
      end
      if (ctrl_we_s) begin
        gen_r <= cfg_wdata[CTRL_GEN_BIT];
      end
    end
  end

  // Registered delivery outputs; id and vector hold until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_r  <= 1'b0;
      in_service_r <= 1'b0;
      active_id_r  <= 3'd0;
      vector_r     <= VEC_BASE;
    end else begin
      interrupt_r  <= grant_s;
      in_service_r <= (state_nxt_s == S_ISSUE) || (state_nxt_s == S_SERVICE);
      if (grant_s) begin
        active_id_r <= win_s;
        vector_r    <= vec_nxt_s;
      end
    end
  end

  assign cfg_rdata  = rdata_s;
  assign interrupt  = interrupt_r;
  assign vector     = vector_r;
  assign active_id  = active_id_r;
  assign in_service = in_service_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_irq_scheduler.sv
// Self-checking bench for irq_scheduler: scenario tasks plus a scoreboard of
// expected {active_id, vector} pairs consumed on every interrupt pulse.
module tb_irq_scheduler;

  localparam logic [5:0] RET_OP = 6'b010000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic [5:0]  op;
  logic        cfg_we;
  logic        cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        interrupt;
  logic [15:0] vector;
  logic [2:0]  active_id;
  logic        in_service;
  logic [3:0]  pending;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_e;

  always #5 clk = ~clk;

  irq_scheduler #(.NUM_SRC(4), .VEC_BASE(16'hF000), .VEC_STRIDE(16'h0010)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .op(op),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .interrupt(interrupt), .vector(vector), .active_id(active_id),
    .in_service(in_service), .pending(pending)
  );

  function automatic logic [15:0] exp_vec(input int id);
    logic [15:0] v;
`ifdef IRQ_VECTORED_EN
    v = 16'hF000 + 16'(id) * 16'h0010;
`else
    v = 16'hF000;
`endif
    return v;
  endfunction

  // Scoreboard: every interrupt pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (interrupt === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_irq: got id=%0d vector=%h, none expected", active_id, vector);
      end else begin
        exp_e = exp_q.pop_front();
        if ({active_id, vector} !== exp_e) begin
          bad++;
          $display("FAIL irq_entry: got id=%0d vector=%h, want id=%0d vector=%h",
                   active_id, vector, exp_e[18:16], exp_e[15:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0; cfg_wdata = 16'h0000;
  endtask

  task automatic ret_op();
    op = RET_OP;
    cyc();
    op = 6'b000000;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    total++;
    if ({interrupt, in_service, active_id, pending, vector} !== {1'b0, 1'b0, 3'd0, 4'b0000, 16'hF000}) begin
      bad++;
      $display("FAIL reset_outputs: got irq=%b svc=%b id=%0d pend=%b vec=%h, want 0 0 0 0000 f000",
               interrupt, in_service, active_id, pending, vector);
    end
    cfg_addr = 1'b0; #1;
    total++;
    if (cfg_rdata !== 16'h0000) begin bad++; $display("FAIL reset_mask: got %h want 0000", cfg_rdata); end
    cfg_addr = 1'b1; #1;
    total++;
    if (cfg_rdata !== 16'h0000) begin bad++; $display("FAIL reset_ctrl: got %h want 0000", cfg_rdata); end
  endtask

  task automatic test_single();
    cfg_wr(1'b1, 16'h0001);
    irq_src = 4'b0100; exp_q.push_back({3'd2, exp_vec(2)});
    cyc();
    total++;
    if ({interrupt, pending} !== {1'b0, 4'b0100}) begin
      bad++; $display("FAIL single_e0: got irq=%b pend=%b want 0 0100", interrupt, pending);
    end
    cyc();
    total++;
    if ({interrupt, active_id, pending, in_service, vector} !== {1'b1, 3'd2, 4'b0000, 1'b1, exp_vec(2)}) begin
      bad++; $display("FAIL single_e1: got irq=%b id=%0d pend=%b svc=%b vec=%h want 1 2 0000 1 %h",
                      interrupt, active_id, pending, in_service, vector, exp_vec(2));
    end
    cyc();
    total++;
    if ({interrupt, in_service} !== 2'b01) begin
      bad++; $display("FAIL single_e2: got irq=%b svc=%b want 0 1", interrupt, in_service);
    end
    repeat (4) cyc();
    total++;
    if ({pending, in_service} !== {4'b0000, 1'b1}) begin
      bad++; $display("FAIL single_level: got pend=%b svc=%b want 0000 1", pending, in_service);
    end
    irq_src = 4'b0000;
    ret_op();
    total++;
    if ({in_service, vector} !== {1'b0, exp_vec(2)}) begin
      bad++; $display("FAIL single_ret: got svc=%b vec=%h want 0 %h", in_service, vector, exp_vec(2));
    end
    cyc();
  endtask

  task automatic test_priority();
    irq_src = 4'b1010;
    exp_q.push_back({3'd1, exp_vec(1)});
    exp_q.push_back({3'd3, exp_vec(3)});
    cyc();
    irq_src = 4'b0000;
    cyc();
    total++;
    if ({interrupt, active_id, pending} !== {1'b1, 3'd1, 4'b1000}) begin
      bad++; $display("FAIL prio_grant: got irq=%b id=%0d pend=%b want 1 1 1000", interrupt, active_id, pending);
    end
    cyc();
    cfg_addr = 1'b1; #1;
    total++;
    if (cfg_rdata !== 16'h0021) begin bad++; $display("FAIL prio_ctrl_rd: got %h want 0021", cfg_rdata); end
    ret_op();
    cyc();
    total++;
    if (interrupt !== 1'b0) begin bad++; $display("FAIL prio_r1: got irq=%b want 0", interrupt); end
    cyc();
    total++;
    if ({interrupt, active_id} !== {1'b1, 3'd3}) begin
      bad++; $display("FAIL prio_r2: got irq=%b id=%0d want 1 3", interrupt, active_id);
    end
    cyc(); ret_op(); cyc();
  endtask

  task automatic test_mask();
    cfg_wr(1'b0, 16'h0001);
    irq_src = 4'b0001; cyc(); irq_src = 4'b0000;
    repeat (3) cyc();
    cfg_addr = 1'b0; #1;
    total++;
    if ({pending, in_service, cfg_rdata} !== {4'b0001, 1'b0, 16'h0001}) begin
      bad++; $display("FAIL mask_hold: got pend=%b svc=%b rd=%h want 0001 0 0001", pending, in_service, cfg_rdata);
    end
    exp_q.push_back({3'd0, exp_vec(0)});
    cfg_wr(1'b0, 16'h0000);
    total++;
    if (interrupt !== 1'b0) begin bad++; $display("FAIL mask_w0: got irq=%b want 0", interrupt); end
    cyc();
    total++;
    if ({interrupt, active_id} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL mask_w1: got irq=%b id=%0d want 1 0", interrupt, active_id);
    end
    cyc(); ret_op(); cyc();
  endtask

  task automatic test_sw_clear();
    cfg_wr(1'b1, 16'h0000);
    irq_src = 4'b0100; cyc(); irq_src = 4'b0000; cyc();
    cfg_addr = 1'b1; #1;
    total++;
    if ({pending, cfg_rdata} !== {4'b0100, 16'h0010}) begin
      bad++; $display("FAIL clr_pre: got pend=%b rd=%h want 0100 0010", pending, cfg_rdata);
    end
    cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 16'h0002; irq_src = 4'b0010;
    cyc();
    cfg_we = 1'b0; cfg_wdata = 16'h0000; irq_src = 4'b0000;
    #1;
    total++;
    if ({pending, cfg_rdata} !== {4'b0010, 16'h0008}) begin
      bad++; $display("FAIL clr_edge_wins: got pend=%b rd=%h want 0010 0008", pending, cfg_rdata);
    end
    cfg_wr(1'b1, 16'h0002);
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL clr_all: got pend=%b want 0000", pending); end
  endtask

  task automatic test_simul_set_clear();
    irq_src = 4'b0001; cyc(); irq_src = 4'b0000; cyc();
    exp_q.push_back({3'd0, exp_vec(0)});
    exp_q.push_back({3'd0, exp_vec(0)});
    cfg_wr(1'b1, 16'h0001);
    irq_src = 4'b0001;
    cyc();
    total++;
    if ({interrupt, pending} !== {1'b1, 4'b0001}) begin
      bad++; $display("FAIL simul_grant: got irq=%b pend=%b want 1 0001", interrupt, pending);
    end
    irq_src = 4'b0000;
    cyc(); cyc(); ret_op(); cyc(); cyc();
    total++;
    if ({interrupt, active_id} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL simul_reissue: got irq=%b id=%0d want 1 0", interrupt, active_id);
    end
    cyc(); ret_op(); cyc();
  endtask

  task automatic test_back_to_back();
    irq_src = 4'b0001; exp_q.push_back({3'd0, exp_vec(0)});
    cyc(); cyc();
    irq_src = 4'b0000;
    cyc(); cyc();
    irq_src = 4'b0001; exp_q.push_back({3'd0, exp_vec(0)});
    cyc(); irq_src = 4'b0000;
    repeat (4) cyc();
    total++;
    if ({interrupt, pending, in_service} !== {1'b0, 4'b0001, 1'b1}) begin
      bad++; $display("FAIL holdoff: got irq=%b pend=%b svc=%b want 0 0001 1", interrupt, pending, in_service);
    end
    ret_op();
    cyc();
    total++;
    if (interrupt !== 1'b0) begin bad++; $display("FAIL holdoff_r1: got irq=%b want 0", interrupt); end
    cyc();
    total++;
    if (interrupt !== 1'b1) begin bad++; $display("FAIL holdoff_r2: got irq=%b want 1", interrupt); end
    cyc(); ret_op(); cyc();
  endtask

  task automatic test_reset_mid();
    irq_src = 4'b0001; exp_q.push_back({3'd0, exp_vec(0)});
    cyc(); cyc();
    irq_src = 4'b0000; cyc();
    irq_src = 4'b0110; cyc();
    irq_src = 4'b0000; cyc();
    total++;
    if ({pending, in_service} !== {4'b0110, 1'b1}) begin
      bad++; $display("FAIL rmid_pre: got pend=%b svc=%b want 0110 1", pending, in_service);
    end
    reset = 1'b1; cyc(); reset = 1'b0;
    cfg_addr = 1'b1; #1;
    total++;
    if ({interrupt, in_service, active_id, pending, vector, cfg_rdata} !==
        {1'b0, 1'b0, 3'd0, 4'b0000, 16'hF000, 16'h0000}) begin
      bad++; $display("FAIL rmid_reset: got irq=%b svc=%b id=%0d pend=%b vec=%h rd=%h want 0 0 0 0000 f000 0000",
                      interrupt, in_service, active_id, pending, vector, cfg_rdata);
    end
    irq_src = 4'b0010; cyc(); irq_src = 4'b0000;
    repeat (4) cyc();
    total++;
    if ({pending, in_service} !== {4'b0010, 1'b0}) begin
      bad++; $display("FAIL rmid_gen_off: got pend=%b svc=%b want 0010 0", pending, in_service);
    end
    exp_q.push_back({3'd1, exp_vec(1)});
    cfg_wr(1'b1, 16'h0001);
    cyc();
    total++;
    if ({interrupt, active_id} !== {1'b1, 3'd1}) begin
      bad++; $display("FAIL rmid_regen: got irq=%b id=%0d want 1 1", interrupt, active_id);
    end
    cyc(); ret_op(); cyc();
  endtask

  initial begin
    reset = 1'b1; irq_src = 4'b0000; op = 6'b000000;
    cfg_we = 1'b0; cfg_addr = 1'b0; cfg_wdata = 16'h0000;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_sw_clear();
    test_simul_set_clear();
    test_back_to_back();
    test_reset_mid();
    repeat (3) cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_scheduler.md
# irq_scheduler

Multi-source interrupt scheduler for the 16-bit MIPS core. It captures rising edges on several external interrupt lines, masks and prioritises them, and delivers one interrupt at a time to the jump control block as a single-cycle `interrupt` pulse with an entry vector. It holds off further requests until the handler's RET is decoded. It sits between the external IRQ pins, the decode stage (opcode) and the jump control block, and is configured through a small register port.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources (1..8).
- `VEC_BASE`, 16'hF000: entry address of source 0 / common entry.
- `VEC_STRIDE`, 16'h0010: address spacing between per-source vectors.

Ports (reset synchronous, active-high; clock `clk`):
- `clk` in 1: clock; all state on posedge.
- `reset` in 1: synchronous, active-high.
- `irq_src` in NUM_SRC: external request lines; rising edge = request.
- `op` in 6: decode-stage opcode; 6'b010000 = RET.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 1: 0 = MASK, 1 = CTRL.
- `cfg_wdata` in 16: write data.
- `cfg_rdata` out 16: combinational readback of `cfg_addr`.
- `interrupt` out 1: one-cycle pulse to jump control.
- `vector` out 16: entry address, valid while `interrupt`=1 and held through service.
- `active_id` out 3: index of the source in service.
- `in_service` out 1: high from the ISSUE cycle until RET is seen.
- `pending` out NUM_SRC: latched, not-yet-serviced requests.

## Operation
- Edge detect: `src_q` holds the previous sample of `irq_src`. `irq_src[i] & ~src_q[i]` sets `pending[i]`. Levels held high do not re-trigger.
- MASK register: bit i = 1 masks source i. Masked requests still latch in `pending` but are not eligible.
- CTRL register:
  - bit0 = global enable (GEN).
  - bit1 = write-1 clears all pending (self-clearing, reads 0).
- Readback:
  - MASK reads {zero-pad, mask}.
  - CTRL reads {zero-pad, pending[NUM_SRC-1:0] at bits [NUM_SRC+1:2], 1'b0, GEN}.
- Eligible = `pending & ~mask`, gated by GEN. Fixed priority: lowest index wins.
- FSM states:
  - IDLE: if any source is eligible, go to ISSUE. Latch `active_id` = winner and clear its pending bit.
  - ISSUE: `interrupt`=1 for exactly one cycle, then go to SERVICE.
  - SERVICE: wait for `op`==RET, then go to RETIRE. No new issue is possible.
  - RETIRE: one cycle; `in_service` drops, then go to IDLE. This guarantees the jump control RET/flag restore completes before the next entry.
- Simultaneous events:
  - New edge on the source being cleared at grant: set wins; the bit stays pending.
  - Software clear and a new edge in the same cycle: edge wins for that bit.
  - Config write in the same cycle as grant: grant uses the pre-write mask.
- Masking or clearing GEN during SERVICE does not abort the handler.
- RET seen in IDLE/ISSUE is ignored.

## Timing
- Reset values:
  - Outputs: `interrupt`=0, `in_service`=0, `active_id`=0, `pending`=0, `vector`=VEC_BASE.
  - Registers: mask=0, GEN=0, `src_q`=0, state IDLE.
- Reset mid-service returns to IDLE immediately and drops all pending requests.
- Latency, edge sampled at posedge E0:
  - `pending` is set after E0.
  - ISSUE is entered at E1, so `interrupt` is high for E1..E2.
  - This is 2 cycles minimum, when the scheduler is IDLE and the source is eligible.
- RET sampled at posedge R: RETIRE for R..R+1, IDLE at R+1. The earliest next `interrupt` is at R+2.
- `vector` and `active_id` are registered, stable from E1 until the next grant.

## Configuration
- `IRQ_VECTORED_EN` defined: `vector` = VEC_BASE + active_id*VEC_STRIDE. Arithmetic is 16-bit and truncating; wrap-around is permitted.
- Not defined: `vector` = VEC_BASE for every source. This matches the fixed F000 entry of jump control. `active_id` is still reported, so software polls it to dispatch.

## Structure
- Shared package `irq_pkg`:
  - state enum (IDLE, ISSUE, SERVICE, RETIRE).
  - `OP_RET` = 6'b010000.
  - CTRL bit positions, and `CFG_MASK`/`CFG_CTRL` addresses.
- One natural sub-module: `irq_prio_enc`, a combinational lowest-index priority encoder (NUM_SRC -> valid + 3-bit index).

## Test plan
- Single source: GEN=1, rise `irq_src[2]` at E0 -> `interrupt` pulses at E1 only; `active_id`=2; `vector`=16'hF020 (vectored) or 16'hF000 (not vectored); `pending[2]`=0.
- Priority: sources 1 and 3 rise in the same cycle -> source 1 issues. Source 3 stays pending, and after RET issues 2 cycles later with `vector`=16'hF030.
- Mask: MASK=4'b0001, rise source 0 -> `pending`=0001 and no issue. Write MASK=0 -> issue next cycle +1.
- Hold-off: rise source 0 during SERVICE -> no `interrupt` until RET. After RET at R, `interrupt` appears at R+2.
- Simultaneous set and clear: source 0 re-rises in its grant cycle -> `pending[0]`=1 after grant. Source 0 issues again after RET.
- Reset mid-service: pulse `reset` during SERVICE with pending=0110 -> all outputs at reset values. No `interrupt` afterwards until GEN is rewritten.
